// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle control FSM and the core datapath.
// master: the control FSM (consumes opcode/flags/mem_ready, drives selects and enables).
// slave : the datapath/memory side (drives opcode/flags/mem_ready, consumes controls).
interface multicycle_ctrl_if;
  logic [6:0] instr_op;       // opcode field instr[6:0]
  logic       alu_zero;       // ALU zero flag
  logic       mem_ready;      // memory accepted/completed current request
  logic       mem_req;        // memory request valid
  logic       mem_we;         // memory write enable (valid with mem_req)
  logic       adr_src;        // 0 = PC, 1 = ALU result register
  logic       ir_write;       // load IR and old-PC register
  logic       pc_write;       // load PC from result bus
  logic       reg_write;      // register file write enable
  logic [1:0] imm_src;        // 00 I, 01 S, 10 B
  logic [1:0] alu_src_a;      // 00 PC, 01 old PC, 10 rs1
  logic [1:0] alu_src_b;      // 00 rs2, 01 imm, 10 const 4
  logic [1:0] alu_op;         // 00 add, 01 sub, 10 funct decode
  logic [1:0] result_src;     // 00 ALU reg, 01 read data, 10 ALU direct
  logic       instr_retired;  // one-cycle pulse per completed instruction
  logic       fault;          // sticky fault indication
  logic [3:0] state_o;        // current state encoding

  modport master (
    input  instr_op, alu_zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_src,
           alu_src_a, alu_src_b, alu_op, result_src, instr_retired, fault, state_o
  );

  modport slave (
    output instr_op, alu_zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_src,
           alu_src_a, alu_src_b, alu_op, result_src, instr_retired, fault, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32 core. Sequences fetch, decode, execute,
// memory and writeback over a shared ALU and memory port, with a memory-wait
// watchdog that drops into a sticky FAULT state.
// Ports:
//   clk - core clock
//   rst - asynchronous active-high reset
//   bus - multicycle_ctrl_if.master: opcode/flags/mem_ready in, datapath controls out
module multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_FAULT    = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [15:0] WaitLimit = 16'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_d;
  logic        w_waiting;
  logic        w_timeout;

  logic       w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
  logic       w_retired, w_fault;
  logic [1:0] w_imm_src, w_src_a, w_src_b, w_alu_op, w_result_src;

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                     (r_state == S_MEMWRITE);
  // mem_ready in the limit cycle wins over the timeout.
  assign w_timeout = w_waiting && !bus.mem_ready && (r_wait_cnt == WaitLimit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_d;
    end
  end

  // Next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (bus.instr_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_BEQ:       w_next = S_BRANCH;
          default:      w_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (bus.instr_op == OP_SW)      w_next = S_MEMWRITE;
        else if (bus.instr_op == OP_LW) w_next = S_MEMREAD;
        else                            w_next = S_FAULT;
      end
      S_MEMREAD: begin
        if (bus.mem_ready)  w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWB: w_next = S_FETCH;
      S_MEMWRITE: begin
        if (bus.mem_ready)  w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_EXEC_R: w_next = S_ALU_WB;
      S_EXEC_I: w_next = S_ALU_WB;
      S_ALU_WB: w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
  end

  // Wait counter: clears on any state change, counts non-ready wait cycles.
  always_comb begin
    w_wait_cnt_d = r_wait_cnt;
    if (w_next != r_state)                 w_wait_cnt_d = 16'd0;
    else if (w_waiting && !bus.mem_ready)  w_wait_cnt_d = r_wait_cnt + 16'd1;
  end

  // Outputs: Moore from state; ir/pc write and the MEMWRITE retire pulse are qualified.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_retired    = 1'b0;
    w_fault      = 1'b0;
    w_imm_src    = 2'b00;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_alu_op     = 2'b00;
    w_result_src = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        w_src_a   = 2'b01;
        w_src_b   = 2'b01;
        w_imm_src = 2'b10;
      end
      S_MEMADR: begin
        w_src_a   = 2'b10;
        w_src_b   = 2'b01;
        w_imm_src = (bus.instr_op == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retired    = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_adr_src = 1'b1;
        w_retired = bus.mem_ready;
      end
      S_EXEC_R: begin
        w_src_a  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXEC_I: begin
        w_src_a  = 2'b10;
        w_src_b  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_retired   = 1'b1;
      end
      S_BRANCH: begin
        w_src_a    = 2'b10;
        w_alu_op   = 2'b01;
        w_imm_src  = 2'b10;
        w_pc_write = bus.alu_zero;
        w_retired  = 1'b1;
      end
      S_FAULT: w_fault = 1'b1;
      default: ;
    endcase
    // While reset is held, no request or write enable may be asserted.
    if (rst) begin
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_ir_write  = 1'b0;
      w_pc_write  = 1'b0;
      w_reg_write = 1'b0;
      w_retired   = 1'b0;
    end
  end

  assign bus.mem_req       = w_mem_req;
  assign bus.mem_we        = w_mem_we;
  assign bus.adr_src       = w_adr_src;
  assign bus.ir_write      = w_ir_write;
  assign bus.pc_write      = w_pc_write;
  assign bus.reg_write     = w_reg_write;
  assign bus.imm_src       = w_imm_src;
  assign bus.alu_src_a     = w_src_a;
  assign bus.alu_src_b     = w_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.result_src    = w_result_src;
  assign bus.instr_retired = w_retired;
  assign bus.fault         = w_fault;
  assign bus.state_o       = r_state;

endmodule
